// File: rtl/frame_loader.sv
// Streams weight and image bytes from an upstream valid/ready source into the core RAMs
// through a 4-entry FIFO, then waits for the core's result flag or a timeout.
module frame_loader #(
    parameter int unsigned W_BYTES = 54,
    parameter int unsigned D_BYTES = 64,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       reuse_w,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       mode,
    output logic [7:0] din,
    output logic       ram_en,
    input  logic       out_data_flag,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout
);

    localparam int unsigned ACC_W = $clog2(W_BYTES + D_BYTES + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_D, WAIT_OUT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [4];
    logic [1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d, target;
    logic [6:0]         iss_q, iss_d;
    logic [7:0]         tmr_q, tmr_d;
    logic               wv_q, wv_d;
    logic               full_load_q, full_load_d;
    logic               mode_q, mode_d;
    logic [7:0]         din_q, din_d;
    logic               ram_en_q, ram_en_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               push, pop, rdy;

    always_comb begin
        state_d     = state_q;
        wv_d        = wv_q;
        full_load_d = full_load_q;
        mode_d      = mode_q;
        din_d       = din_q;
        iss_d       = iss_q;
        tmr_d       = '0;
        done_d      = 1'b0;
        tmo_d       = 1'b0;

        // Target stays at the whole-frame total after the weight phase hands over to LOAD_D.
        target = full_load_q ? ACC_W'(W_BYTES + D_BYTES) : ACC_W'(D_BYTES);
        rdy    = (cnt_q != 3'd4) && (state_q != IDLE) && (acc_q < target);
        push   = s_valid && rdy;
        pop    = ((state_q == LOAD_W) || (state_q == LOAD_D)) && (cnt_q != 3'd0);

        wr_d     = wr_q + 2'(push);
        rd_d     = rd_q + 2'(pop);
        cnt_d    = cnt_q + 3'(push) - 3'(pop);
        acc_d    = acc_q + ACC_W'(push);
        ram_en_d = pop;

        if (pop) begin
            din_d  = mem_q[rd_q];
            mode_d = (state_q == LOAD_D);
            iss_d  = iss_q + 7'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    iss_d = '0;
                    if (reuse_w && wv_q) begin
                        state_d     = LOAD_D;
                        full_load_d = 1'b0;
                    end else begin
                        state_d     = LOAD_W;
                        full_load_d = 1'b1;
                        mode_d      = 1'b0;
                    end
                end
            end
            LOAD_W: begin
                if (pop && (iss_q == 7'(W_BYTES - 1))) begin
                    state_d = LOAD_D;
                    wv_d    = 1'b1;
                    iss_d   = '0;
                end
            end
            LOAD_D: begin
                if (pop && (iss_q == 7'(D_BYTES - 1))) begin
                    state_d = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (out_data_flag) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q == 8'(TMO_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    wv_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            iss_q       <= '0;
            tmr_q       <= '0;
            wv_q        <= 1'b0;
            full_load_q <= 1'b0;
            mode_q      <= 1'b0;
            din_q       <= '0;
            ram_en_q    <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            iss_q       <= iss_d;
            tmr_q       <= tmr_d;
            wv_q        <= wv_d;
            full_load_q <= full_load_d;
            mode_q      <= mode_d;
            din_q       <= din_d;
            ram_en_q    <= ram_en_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= s_data;
        end
    end

    assign s_ready    = rdy;
    assign busy       = (state_q != IDLE);
    assign mode       = mode_q;
    assign din        = din_q;
    assign ram_en     = ram_en_q;
    assign frame_done = done_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: accepted bytes go into a scoreboard queue and are
// matched against each ram_en write; completion, timeout and reset-abort are checked.
module tb_frame_loader;

    localparam int unsigned W   = 54;
    localparam int unsigned D   = 64;
    localparam int unsigned TMO = 20;

    logic       clk = 1'b0;
    logic       rst, start, reuse_w, s_valid, out_data_flag;
    logic [7:0] s_data, din;
    logic       s_ready, mode, ram_en, busy, frame_done, timeout;

    always #5 clk = ~clk;

    frame_loader #(.W_BYTES(W), .D_BYTES(D), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mode(mode), .din(din), .ram_en(ram_en), .out_data_flag(out_data_flag),
        .busy(busy), .frame_done(frame_done), .timeout(timeout)
    );

    typedef struct {
        logic        mode;
        logic [7:0]  data;
        int unsigned edge_no;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0, passes = 0, cyc = 0, n_m0 = 0, n_m1 = 0;
    bit          exact_lat = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ram_en === 1'b1) begin
            if (mode === 1'b0) n_m0++; else n_m1++;
            if (sb.size() == 0) begin
                chk("ram_en_extra", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("din", 32'(din), 32'(e.data));
                chk("mode", 32'(mode), 32'(e.mode));
                if (exact_lat) chk("latency", cyc - e.edge_no, 32'd1);
                else           chk("latency_min", 32'(cyc >= e.edge_no + 1), 32'd1);
            end
        end
    endtask

    task automatic start_frame(input logic r);
        start   = 1'b1;
        reuse_w = r;
        tick();
        start   = 1'b0;
        reuse_w = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_frame(input bit wphase, input int unsigned n_stop, input bit drain,
                              input int unsigned pct);
        int unsigned idx = 0, budget = 0;
        bit          v;
        exp_t        e;
        n_m0      = 0;
        n_m1      = 0;
        exact_lat = (pct >= 100);
        while (!((idx == n_stop) && (!drain || sb.size() == 0)) && budget < 2000) begin
            v       = (idx < n_stop) && ($urandom_range(99) < pct);
            s_valid = v;
            s_data  = 8'($urandom_range(255));
            if (v && s_ready) begin
                e.mode    = !(wphase && idx < W);
                e.data    = s_data;
                e.edge_no = cyc + 1;
                sb.push_back(e);
                idx++;
            end
            tick();
            budget++;
        end
        s_valid = 1'b0;
        chk("frame_budget", 32'(budget < 2000), 32'd1);
    endtask

    task automatic wait_out(input int unsigned flag_c);
        bit          flagged = (flag_c >= 1) && (flag_c <= TMO);
        int unsigned end_c   = flagged ? flag_c : TMO;
        for (int unsigned c = 1; c <= end_c + 1; c++) begin
            out_data_flag = (c == flag_c);
            start         = (c <= end_c);
            reuse_w       = start;
            tick();
            chk("frame_done", 32'(frame_done), 32'(c == end_c && flagged));
            chk("timeout", 32'(timeout), 32'(c == end_c && !flagged));
            chk("busy_wait", 32'(busy), 32'(c < end_c));
        end
        out_data_flag = 1'b0;
        start         = 1'b0;
        reuse_w       = 1'b0;
    endtask

    task automatic full_frame_checks(input int unsigned e0, input int unsigned e1);
        chk("s_ready_after_last", 32'(s_ready), 32'd0);
        chk("pulses_mode0", n_m0, e0);
        chk("pulses_mode1", n_m1, e1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_din"}, 32'(din), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reuse_w = 1'b0; s_valid = 1'b0;
        s_data = '0; out_data_flag = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Reuse requested with no valid weights: full load, continuous stream.
        start_frame(1'b1);
        send_frame(1'b1, W + D, 1'b1, 100);
        full_frame_checks(W, D);
        wait_out(10);

        // Weight reuse with 50% gaps; flag arrives on the expiry cycle.
        start_frame(1'b1);
        send_frame(1'b0, D, 1'b1, 50);
        full_frame_checks(0, D);
        wait_out(TMO);

        // Full load with gaps, then timeout.
        start_frame(1'b0);
        send_frame(1'b1, W + D, 1'b1, 50);
        full_frame_checks(W, D);
        wait_out(0);

        // Timeout invalidated the weights.
        start_frame(1'b1);
        send_frame(1'b1, W + D, 1'b1, 100);
        full_frame_checks(W, D);
        wait_out(3);

        // Reset after 30 image bytes of a reuse frame.
        start_frame(1'b1);
        send_frame(1'b0, 30, 1'b0, 100);
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst = 1'b0;
        sb.delete();
        out_data_flag = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("idle_flag_done", 32'(frame_done), 32'd0);
            chk("idle_flag_tmo", 32'(timeout), 32'd0);
            chk("idle_ram_en", 32'(ram_en), 32'd0);
        end
        out_data_flag = 1'b0;

        start_frame(1'b1);
        send_frame(1'b1, W + D, 1'b1, 100);
        full_frame_checks(W, D);
        wait_out(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
